// File: rtl/toggle_pattern_gen.sv
// Multi-channel square-wave stimulus generator with programmable per-channel
// half-periods and a registered AND/OR/XOR/NAND reduction of the channel outputs.
module toggle_pattern_gen #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 1,
    parameter int CH_W     = $clog2(N_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_restart,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_half,
    input  logic [1:0]        i_red_mode,
    output logic [N_CH-1:0]   o_ch_out,
    output logic              o_red_out
);

    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [CNT_W-1:0] r_half [N_CH];
    logic [N_CH-1:0]  r_ch;
    logic             r_red;

    logic [N_CH-1:0]  w_wr;
    logic [N_CH-1:0]  w_tc;
    logic             w_red_next;

    // Out-of-range channel indices never match, so such writes are dropped.
    always_comb begin
        w_wr = '0;
        w_tc = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr[i] = i_cfg_we && (i_cfg_ch == CH_W'(i));
            w_tc[i] = (r_half[i] != '0) && (r_cnt[i] == r_half[i] - CNT_W'(1));
        end
    end

    always_comb begin
        w_red_next = 1'b0;
        case (i_red_mode)
            2'b00:   w_red_next = &r_ch;
            2'b01:   w_red_next = |r_ch;
            2'b10:   w_red_next = ^r_ch;
            default: w_red_next = ~&r_ch;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch  <= '0;
            r_red <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= '0;
                r_half[i] <= CNT_W'(DEF_HALF);
            end
        end else begin
            r_red <= w_red_next;
            for (int i = 0; i < N_CH; i++) begin
                if (i_restart) begin
                    r_cnt[i] <= '0;
                    r_ch[i]  <= 1'b0;
                    if (w_wr[i]) begin
                        r_half[i] <= i_cfg_half;
                    end
                end else if (w_wr[i]) begin
                    // A write re-phases the channel and suppresses any toggle due this edge.
                    r_half[i] <= i_cfg_half;
                    r_cnt[i]  <= '0;
                end else if (i_en && (r_half[i] != '0)) begin
                    if (w_tc[i]) begin
                        r_cnt[i] <= '0;
                        r_ch[i]  <= ~r_ch[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_ch_out  = r_ch;
    assign o_red_out = r_red;

endmodule

// File: tb/tb_toggle_pattern_gen.sv
// Bench for toggle_pattern_gen: directed and random stimulus checked every cycle
// against a model that derives each channel from elapsed enabled cycles.
module tb_toggle_pattern_gen;

    localparam int NCH   = 5;
    localparam int CW    = 8;
    localparam int DEFH  = 1;
    localparam int CHW   = $clog2(NCH);

    logic            clk = 1'b0;
    logic            rst, en, restart, cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic [CW-1:0]   cfg_half;
    logic [1:0]      red_mode;
    logic [NCH-1:0]  ch_out;
    logic            red_out;

    int n_vec = 0;
    int n_err = 0;

    // Model: a channel's level is its base level flipped once per P enabled cycles
    // elapsed since the last re-phase (write, restart or reset).
    int   m_p    [NCH];
    bit   m_base [NCH];
    int   m_el   [NCH];
    bit   m_red;

    toggle_pattern_gen #(.N_CH(NCH), .CNT_W(CW), .DEF_HALF(DEFH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_restart  (restart),
        .i_cfg_we   (cfg_we),
        .i_cfg_ch   (cfg_ch),
        .i_cfg_half (cfg_half),
        .i_red_mode (red_mode),
        .o_ch_out   (ch_out),
        .o_red_out  (red_out)
    );

    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] model_ch();
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_p[i] == 0) v[i] = m_base[i];
            else             v[i] = m_base[i] ^ bit'((m_el[i] / m_p[i]) % 2);
        end
        return v;
    endfunction

    task automatic model_edge();
        logic [NCH-1:0] pre;
        int ones;
        bit wr;
        pre  = model_ch();
        ones = $countones(pre);
        if (rst) begin
            m_red = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_p[i] = DEFH; m_base[i] = 1'b0; m_el[i] = 0;
            end
            return;
        end
        case (red_mode)
            2'd0:    m_red = (ones == NCH);
            2'd1:    m_red = (ones > 0);
            2'd2:    m_red = (ones % 2) == 1;
            default: m_red = (ones != NCH);
        endcase
        for (int i = 0; i < NCH; i++) begin
            wr = cfg_we && (int'(cfg_ch) == i);
            if (restart) begin
                m_base[i] = 1'b0; m_el[i] = 0;
                if (wr) m_p[i] = int'(cfg_half);
            end else if (wr) begin
                m_base[i] = pre[i]; m_el[i] = 0; m_p[i] = int'(cfg_half);
            end else if (en && m_p[i] > 0) begin
                m_el[i]++;
            end
        end
    endtask

    task automatic cyc(input string tag);
        logic [NCH-1:0] exp_ch;
        @(posedge clk);
        model_edge();
        #1;
        exp_ch = model_ch();
        n_vec++;
        assert (ch_out === exp_ch) else begin
            n_err++;
            $error("FAIL %s ch_out observed=%b expected=%b", tag, ch_out, exp_ch);
        end
        n_vec++;
        assert (red_out === m_red) else begin
            n_err++;
            $error("FAIL %s red_out observed=%b expected=%b", tag, red_out, m_red);
        end
    endtask

    task automatic write_half(input int ch, input int half);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_half = CW'(half);
        cyc("cfg_write");
        cfg_we = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; en = 1'b0; restart = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_half = '0; red_mode = 2'b00;
        for (int i = 0; i < NCH; i++) begin
            m_p[i] = DEFH; m_base[i] = 1'b0; m_el[i] = 0;
        end
        m_red = 1'b0;

        // Reset, then default half-period 1: all channels toggle every cycle.
        cyc("reset"); cyc("reset");
        rst = 1'b0; en = 1'b1;
        for (int k = 0; k < 8; k++) cyc("default_p1");

        // Mixed half-periods, restart, long run in AND mode.
        en = 1'b0;
        write_half(3, 10); write_half(2, 7); write_half(1, 5); write_half(0, 1); write_half(4, 2);
        restart = 1'b1; cyc("restart"); restart = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 140; k++) cyc("run_and");

        // Freeze and resume mid-run.
        en = 1'b0;
        for (int k = 0; k < 20; k++) cyc("hold");
        en = 1'b1;
        for (int k = 0; k < 30; k++) cyc("resume");

        // Write to ch1 exactly on its terminal-count cycle.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_p[1] > 0 && ((m_el[1] + 1) % m_p[1]) == 0) found = 1'b1;
            else cyc("seek_tc");
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL seek_tc terminal count not reached within bound");
        end
        write_half(1, 3);
        for (int k = 0; k < 10; k++) cyc("after_tc_write");

        // Out-of-range channel writes must leave everything untouched.
        for (int c = NCH; c < (1 << CHW); c++) write_half(c, 0);
        for (int k = 0; k < 25; k++) cyc("after_bad_write");

        // Reduction modes on a frozen pattern.
        en = 1'b0;
        for (int m = 0; m < 4; m++) begin
            red_mode = 2'(m);
            cyc("mode_step"); cyc("mode_hold");
        end

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            en       = ($urandom_range(0, 9) != 0);
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = CHW'($urandom_range(0, (1 << CHW) - 1));
            cfg_half = CW'($urandom_range(0, 12));
            restart  = ($urandom_range(0, 29) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            red_mode = 2'($urandom_range(0, 3));
            cyc("random");
        end
        rst = 1'b0; restart = 1'b0; cfg_we = 1'b0;

        // Reset mid-run: half-periods revert to the default.
        en = 1'b1; red_mode = 2'b01;
        write_half(0, 3); write_half(2, 4); write_half(3, 2);
        for (int k = 0; k < 9; k++) cyc("pre_rst");
        rst = 1'b1; cyc("rst_mid"); rst = 1'b0;
        for (int k = 0; k < 6; k++) cyc("post_rst");

        // Restart mid-run with a same-cycle write: half-periods preserved.
        write_half(0, 3); write_half(2, 4); write_half(3, 2);
        for (int k = 0; k < 9; k++) cyc("pre_restart");
        restart = 1'b1; cfg_we = 1'b1; cfg_ch = CHW'(1); cfg_half = CW'(6);
        cyc("restart_mid");
        restart = 1'b0; cfg_we = 1'b0;
        for (int k = 0; k < 30; k++) cyc("post_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
